// File: rtl/bp_be_late_wb_buffer.sv
// bp_be_late_wb_buffer: in-order late int/fp writeback FIFO with RF drain and dispatch hazard probe.
// Optional BP_LATE_WB_BYPASS_EN: an empty buffer forwards a packet to a free RF port in the same cycle.
module bp_be_late_wb_buffer #(
    parameter int els_p            = 4,
    parameter int reg_addr_width_p = 5,
    parameter int data_width_p     = 66
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        iwb_v_i,
    input  logic                        fwb_v_i,
    input  logic [reg_addr_width_p-1:0] wb_addr_i,
    input  logic [data_width_p-1:0]     wb_data_i,
    output logic                        ready_o,
    input  logic                        irf_busy_i,
    input  logic                        frf_busy_i,
    output logic                        irf_w_v_o,
    output logic                        frf_w_v_o,
    output logic [reg_addr_width_p-1:0] rf_w_addr_o,
    output logic [data_width_p-1:0]     rf_w_data_o,
    input  logic [reg_addr_width_p-1:0] chk_addr_i,
    input  logic                        chk_fp_i,
    output logic                        chk_hit_o,
    output logic                        empty_o
);
    localparam int lg_els_lp = $clog2(els_p);
    localparam int cnt_w_lp  = $clog2(els_p + 1);

    logic [lg_els_lp-1:0]        wptr_r, rptr_r;
    logic [cnt_w_lp-1:0]         count_r;
    logic [els_p-1:0]            v_r, fp_r;
    logic [reg_addr_width_p-1:0] addr_r [els_p];
    logic [data_width_p-1:0]     data_r [els_p];
    logic in_v, empty, head_fp, deq, enq, byp;

    assign in_v    = iwb_v_i | fwb_v_i;
    assign empty   = (count_r == '0);
    assign empty_o = empty;
    assign head_fp = fp_r[rptr_r];
    // A blocked head stalls everything behind it, even entries for the other port.
    assign deq     = ~empty & (head_fp ? ~frf_busy_i : ~irf_busy_i);
    assign ready_o = (count_r != cnt_w_lp'(els_p)) | deq;
`ifdef BP_LATE_WB_BYPASS_EN
    assign byp = empty & in_v & (fwb_v_i ? ~frf_busy_i : ~irf_busy_i);
`else
    assign byp = 1'b0;
`endif
    assign enq         = in_v & ready_o & ~byp;
    assign irf_w_v_o   = (deq & ~head_fp) | (byp & iwb_v_i);
    assign frf_w_v_o   = (deq & head_fp) | (byp & fwb_v_i);
    assign rf_w_addr_o = byp ? wb_addr_i : addr_r[rptr_r];
    assign rf_w_data_o = byp ? wb_data_i : data_r[rptr_r];

    always_comb begin
        chk_hit_o = in_v & (wb_addr_i == chk_addr_i) & (fwb_v_i == chk_fp_i);
        for (int i = 0; i < els_p; i++)
            chk_hit_o = chk_hit_o | (v_r[i] & (addr_r[i] == chk_addr_i) & (fp_r[i] == chk_fp_i));
        // Integer x0 is hardwired, so it can never be a hazard.
        chk_hit_o = chk_hit_o & (chk_fp_i | (chk_addr_i != '0));
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            v_r     <= '0;
        end else begin
            if (deq) begin
                v_r[rptr_r] <= 1'b0;
                rptr_r      <= rptr_r + lg_els_lp'(1);
            end
            if (enq) begin
                v_r[wptr_r] <= 1'b1;
                wptr_r      <= wptr_r + lg_els_lp'(1);
            end
            count_r <= count_r + cnt_w_lp'(enq) - cnt_w_lp'(deq);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            fp_r[wptr_r]   <= fwb_v_i;
            addr_r[wptr_r] <= wb_addr_i;
            data_r[wptr_r] <= wb_data_i;
        end
    end

    a_one_hot_wb: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(iwb_v_i && fwb_v_i));
    a_no_drop:    assert property (@(posedge clk_i) disable iff (!reset_n_i) !(in_v && !ready_o));
endmodule

// File: tb/tb_bp_be_late_wb_buffer.sv
// tb_bp_be_late_wb_buffer: directed stimulus with a write-order scoreboard for bp_be_late_wb_buffer.
module tb_bp_be_late_wb_buffer;
`ifdef BP_LATE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset_n, iwb_v, fwb_v, ready, irf_busy, frf_busy;
    logic        irf_w_v, frf_w_v, chk_fp, chk_hit, empty;
    logic [4:0]  wb_addr, rf_w_addr, chk_addr;
    logic [65:0] wb_data, rf_w_data;
    logic [71:0] sb [$];
    int tests = 0;
    int fails = 0;

    bp_be_late_wb_buffer dut (
        .clk_i(clk), .reset_n_i(reset_n), .iwb_v_i(iwb_v), .fwb_v_i(fwb_v),
        .wb_addr_i(wb_addr), .wb_data_i(wb_data), .ready_o(ready),
        .irf_busy_i(irf_busy), .frf_busy_i(frf_busy), .irf_w_v_o(irf_w_v),
        .frf_w_v_o(frf_w_v), .rf_w_addr_o(rf_w_addr), .rf_w_data_o(rf_w_data),
        .chk_addr_i(chk_addr), .chk_fp_i(chk_fp), .chk_hit_o(chk_hit), .empty_o(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every RF write must match the oldest outstanding accepted packet.
    always @(negedge clk) begin
        if (reset_n && (irf_w_v || frf_w_v)) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: write addr %0h data %0h with nothing pending", rf_w_addr, rf_w_data);
            end else begin
                logic [71:0] e;
                e = sb.pop_front();
                chk("sb_write", {frf_w_v, irf_w_v, rf_w_addr, rf_w_data}, {e[71], ~e[71], e[70:66], e[65:0]});
            end
        end
    end

    task automatic send(input logic fp, input logic [4:0] a, input logic [65:0] d);
        iwb_v = ~fp; fwb_v = fp; wb_addr = a; wb_data = d;
        #1;
        chk("send_ready", ready, 1);
        sb.push_back({fp, a, d});
        @(posedge clk); #1;
        iwb_v = 0; fwb_v = 0;
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 20; i++) begin
            if (empty) break;
            @(posedge clk); #1;
        end
        chk(name, empty, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 0; iwb_v = 0; fwb_v = 0; wb_addr = 0; wb_data = 0;
        irf_busy = 0; frf_busy = 0; chk_addr = 0; chk_fp = 0;
        #2;
        chk("rst_ready", ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_irf", irf_w_v, 0);
        chk("rst_frf", frf_w_v, 0);
        chk("rst_hit", chk_hit, 0);
        @(posedge clk); #1 reset_n = 1;
        @(posedge clk); #1;

        // back-to-back int x5 then fp f3
        iwb_v = 1; wb_addr = 5; wb_data = 66'hA;
        sb.push_back({1'b0, 5'd5, 66'hA});
        #1 chk("b2b_irf_c1", irf_w_v, BYP);
        @(posedge clk); #1;
        iwb_v = 0; fwb_v = 1; wb_addr = 3; wb_data = 66'hB;
        sb.push_back({1'b1, 5'd3, 66'hB});
        #1;
        chk("b2b_irf_c2", irf_w_v, !BYP);
        chk("b2b_frf_c2", frf_w_v, BYP);
        chk("b2b_addr_c2", rf_w_addr, BYP ? 5'd3 : 5'd5);
        chk("b2b_data_c2", rf_w_data, BYP ? 66'hB : 66'hA);
        @(posedge clk); #1 fwb_v = 0;
        #1 chk("b2b_frf_c3", frf_w_v, !BYP);
        wait_empty("b2b_empty");

        // fill with the int port blocked, then full + drain in the same cycle
        irf_busy = 1;
        for (int i = 1; i <= 4; i++) send(0, 5'(i), 66'(32'h10 + i));
        chk("fill_ready", ready, 0);
        chk("fill_empty", empty, 0);
        chk("fill_irf", irf_w_v, 0);
        chk_addr = 3; chk_fp = 0;
        #1 chk("fill_hit", chk_hit, 1);
        irf_busy = 0; iwb_v = 1; wb_addr = 6; wb_data = 66'h16;
        #1 chk("full_drain_ready", ready, 1);
        sb.push_back({1'b0, 5'd6, 66'h16});
        @(posedge clk); #1;
        iwb_v = 0; irf_busy = 1;
        #1 chk("full_count_kept", ready, 0);
        irf_busy = 0;
        wait_empty("full_empty");

        // hazard probe, incoming-packet hit, x0 rule, in-order blocking
        irf_busy = 1;
        send(0, 7, 66'h77);
        chk_addr = 7; chk_fp = 0;
        #1 chk("haz_int7", chk_hit, 1);
        chk_fp = 1;
        #1 chk("haz_fp7", chk_hit, 0);
        fwb_v = 1; wb_addr = 9; wb_data = 66'h99; chk_addr = 9;
        #1 chk("haz_incoming", chk_hit, 1);
        sb.push_back({1'b1, 5'd9, 66'h99});
        @(posedge clk); #1 fwb_v = 0;
        #1 chk("haz_stored_f9", chk_hit, 1);
        chk("order_frf_blocked", frf_w_v, 0);
        send(0, 0, 66'h5);
        chk_addr = 0; chk_fp = 0;
        #1 chk("haz_x0", chk_hit, 0);
        irf_busy = 0;
        wait_empty("haz_empty");
        chk_addr = 7;
        #1 chk("haz_after_drain", chk_hit, 0);

        // reset mid-fill with pending entries and a free port
        irf_busy = 1;
        for (int i = 0; i < 3; i++) send(0, 5'(20 + i), 66'(i));
        #2 reset_n = 0; irf_busy = 0;
        #1;
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_irf", irf_w_v, 0);
        chk("mid_rst_frf", frf_w_v, 0);
        sb.delete();
        @(posedge clk); #1 reset_n = 1;
        @(posedge clk); #1;
        chk("post_rst_empty", empty, 1);

        // latency from an empty buffer
        iwb_v = 1; wb_addr = 9; wb_data = 66'h123;
        sb.push_back({1'b0, 5'd9, 66'h123});
        #1;
        chk("lat_irf_c0", irf_w_v, BYP);
        chk("lat_empty_c0", empty, 1);
        @(posedge clk); #1 iwb_v = 0;
        #1;
        chk("lat_irf_c1", irf_w_v, !BYP);
        chk("lat_empty_c1", empty, BYP);
        wait_empty("lat_empty");
        @(posedge clk); #1;
        chk("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
